// File: rtl/vga_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vgachargen_pkg
//  Description : Shared types and constants for the character/attribute RAM
//                arbiter: owner encoding, response tag and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package vgachargen_pkg;

    // 80x30 cells = 2400 words, so 12 bits of word address
    localparam int CH_ADDR_W = 12;
    localparam int CH_DATA_W = 32;

    // Which side of the arbiter a read response belongs to
    typedef enum logic {
        OWNER_DISP = 1'b0,
        OWNER_BUS  = 1'b1
    } mem_owner_e;

    // One entry of the response tag pipe
    typedef struct packed {
        logic       valid;
        mem_owner_e owner;
    } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/vga_mem_rsp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mem_rsp_pipe
//  Description : Two-stage read-response tag pipe. Stage 1 lines up with the
//                RAM read data; the data is captured into the owner's
//                holding register and the owner's valid pulses from stage 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_rsp_pipe
    import vgachargen_pkg::*;
#(
    parameter int DATA_W = CH_DATA_W
)(
    input  logic              clk_i,
    input  logic              arst_i,
    input  rsp_tag_t          issue_tag_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              disp_rvalid_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    output logic              bus_rvalid_o,
    output logic [DATA_W-1:0] bus_rdata_o
);

    rsp_tag_t          stage1_q;
    rsp_tag_t          stage2_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic [DATA_W-1:0] disp_rdata_d;
    logic [DATA_W-1:0] bus_rdata_q;
    logic [DATA_W-1:0] bus_rdata_d;

    // Tag shift register; reset drops any read still in flight
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= issue_tag_i;
            stage2_q <= stage1_q;
        end
    end

    // Steer the RAM data to its owner; the other holding register keeps its value
    always_comb begin
        disp_rdata_d = disp_rdata_q;
        bus_rdata_d  = bus_rdata_q;
        if (stage1_q.valid) begin
            if (stage1_q.owner == OWNER_DISP) begin
                disp_rdata_d = mem_rdata_i;
            end else begin
                bus_rdata_d  = mem_rdata_i;
            end
        end
    end

    // Per-owner read data holding registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            disp_rdata_q <= '0;
            bus_rdata_q  <= '0;
        end else begin
            disp_rdata_q <= disp_rdata_d;
            bus_rdata_q  <= bus_rdata_d;
        end
    end

    assign disp_rvalid_o = stage2_q.valid && (stage2_q.owner == OWNER_DISP);
    assign bus_rvalid_o  = stage2_q.valid && (stage2_q.owner == OWNER_BUS);
    assign disp_rdata_o  = disp_rdata_q;
    assign bus_rdata_o   = bus_rdata_q;

endmodule
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mem_arbiter
//  Description : Shares the single-port character/attribute RAM between the
//                display fetch path (absolute priority) and the bus side.
//                Read data returns two cycles after the access, tagged to
//                its owner. Counts bus requests that lost to the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter
    import vgachargen_pkg::*;
#(
    parameter int ADDR_W         = CH_ADDR_W,
    parameter int DATA_W         = CH_DATA_W,
    parameter int CLK_FACTOR_25M = 4,
    parameter int CNT_W          = 16
)(
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                disp_req_i,
    input  logic [ADDR_W-1:0]   disp_addr_i,
    output logic                disp_rvalid_o,
    output logic [DATA_W-1:0]   disp_rdata_o,
    input  logic                bus_req_i,
    input  logic                bus_we_i,
    input  logic [ADDR_W-1:0]   bus_addr_i,
    input  logic [DATA_W-1:0]   bus_wdata_i,
    input  logic [DATA_W/8-1:0] bus_be_i,
    output logic                bus_gnt_o,
    output logic                bus_rvalid_o,
    output logic [DATA_W-1:0]   bus_rdata_o,
    output logic                mem_en_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic [CNT_W-1:0]    conflict_cnt_o
);

    // The display strobe must leave at least one free cycle, and the data
    // path is split into byte lanes.
    if ((CLK_FACTOR_25M < 2) || ((DATA_W % 8) != 0)) begin : g_param_check
        $error("vga_mem_arbiter: CLK_FACTOR_25M must be >= 2 and DATA_W a multiple of 8");
    end

    rsp_tag_t         issue_tag;
    logic [CNT_W-1:0] conflict_q;
    logic [CNT_W-1:0] conflict_d;

    // Same-cycle arbitration: display first, bus takes any free cycle
    always_comb begin
        mem_en_o        = 1'b0;
        mem_we_o        = '0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        bus_gnt_o       = 1'b0;
        issue_tag       = '0;
        issue_tag.owner = OWNER_DISP;
        if (disp_req_i) begin
            mem_en_o        = 1'b1;
            mem_addr_o      = disp_addr_i;
            issue_tag.valid = 1'b1;
            issue_tag.owner = OWNER_DISP;
        end else if (bus_req_i) begin
            mem_en_o        = 1'b1;
            mem_addr_o      = bus_addr_i;
            mem_wdata_o     = bus_wdata_i;
            mem_we_o        = bus_we_i ? bus_be_i : '0;
            bus_gnt_o       = 1'b1;
            issue_tag.valid = !bus_we_i;
            issue_tag.owner = OWNER_BUS;
        end
    end

    // Saturating count of cycles in which the bus lost to the display
    always_comb begin
        conflict_d = conflict_q;
        if (bus_req_i && disp_req_i && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // Conflict counter register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt_o = conflict_q;

    vga_mem_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .issue_tag_i   (issue_tag),
        .mem_rdata_i   (mem_rdata_i),
        .disp_rvalid_o (disp_rvalid_o),
        .disp_rdata_o  (disp_rdata_o),
        .bus_rvalid_o  (bus_rvalid_o),
        .bus_rdata_o   (bus_rdata_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_mem_arbiter
//  Description : Self-checking bench for vga_mem_arbiter with a behavioural
//                single-port RAM, a table of arbitration vectors, directed
//                multi-cycle sequences and scoreboarded random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          disp_req_i;
    logic [AW-1:0] disp_addr_i;
    logic          disp_rvalid_o;
    logic [DW-1:0] disp_rdata_o;
    logic          bus_req_i;
    logic          bus_we_i;
    logic [AW-1:0] bus_addr_i;
    logic [DW-1:0] bus_wdata_i;
    logic [BW-1:0] bus_be_i;
    logic          bus_gnt_o;
    logic          bus_rvalid_o;
    logic [DW-1:0] bus_rdata_o;
    logic          mem_en_o;
    logic [BW-1:0] mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic [CW-1:0] conflict_cnt_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_mem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .CLK_FACTOR_25M (2),
        .CNT_W          (CW)
    ) dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .disp_req_i     (disp_req_i),
        .disp_addr_i    (disp_addr_i),
        .disp_rvalid_o  (disp_rvalid_o),
        .disp_rdata_o   (disp_rdata_o),
        .bus_req_i      (bus_req_i),
        .bus_we_i       (bus_we_i),
        .bus_addr_i     (bus_addr_i),
        .bus_wdata_i    (bus_wdata_i),
        .bus_be_i       (bus_be_i),
        .bus_gnt_o      (bus_gnt_o),
        .bus_rvalid_o   (bus_rvalid_o),
        .bus_rdata_o    (bus_rdata_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    // Behavioural single-port RAM with one-cycle read latency and a preload port
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_en_o) begin
            mem_rdata_i <= ram[mem_addr_o];
            for (int b = 0; b < BW; b++) begin
                if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    // Display requests must never be back to back
    logic disp_prev = 1'b0;
    always @(posedge clk) begin
        assert (!(disp_prev && disp_req_i)) else $error("disp_req_i high in two consecutive cycles");
        disp_prev <= disp_req_i;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 time units after the edge
    task automatic nxt();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic idle();
        disp_req_i  = 1'b0;
        disp_addr_i = '0;
        bus_req_i   = 1'b0;
        bus_we_i    = 1'b0;
        bus_addr_i  = '0;
        bus_wdata_i = '0;
        bus_be_i    = '0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        nxt();
        pl_en   = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_disp_rvalid"}, disp_rvalid_o, 0);
        chk({nm, "_disp_rdata"},  disp_rdata_o,  0);
        chk({nm, "_bus_rvalid"},  bus_rvalid_o,  0);
        chk({nm, "_bus_rdata"},   bus_rdata_o,   0);
        chk({nm, "_bus_gnt"},     bus_gnt_o,     0);
        chk({nm, "_mem_en"},      mem_en_o,      0);
        chk({nm, "_mem_we"},      mem_we_o,      0);
        chk({nm, "_mem_addr"},    mem_addr_o,    0);
        chk({nm, "_mem_wdata"},   mem_wdata_o,   0);
        chk({nm, "_conflict"},    conflict_cnt_o, 0);
    endtask

    task automatic pulse_reset();
        idle();
        arst = 1'b1;
        nxt();
        arst = 1'b0;
        nxt();
    endtask

    typedef struct {
        logic          d_req;
        logic [AW-1:0] d_addr;
        logic          b_req;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic [BW-1:0] b_be;
        logic          e_en;
        logic [BW-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_gnt;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    vec_t          vecs [6];
    exp_t          dq [$];
    exp_t          bq [$];
    exp_t          e;
    logic [DW-1:0] shadow [0:15];
    logic [DW-1:0] m;
    bit            b_act;
    int            b_wait;

    task automatic check_rsp();
        if (dq.size() > 0 && dq[0].due == cyc) begin
            chk("rnd_disp_rvalid", disp_rvalid_o, 1);
            chk("rnd_disp_rdata", disp_rdata_o, dq[0].data);
            void'(dq.pop_front());
        end else begin
            chk("rnd_disp_rvalid_quiet", disp_rvalid_o, 0);
        end
        if (bq.size() > 0 && bq[0].due == cyc) begin
            chk("rnd_bus_rvalid", bus_rvalid_o, 1);
            chk("rnd_bus_rdata", bus_rdata_o, bq[0].data);
            void'(bq.pop_front());
        end else begin
            chk("rnd_bus_rvalid_quiet", bus_rvalid_o, 0);
        end
    endtask

    initial begin
        //              dreq daddr    breq bwe baddr    bwdata        bbe      en we       addr     wdata         gnt
        vecs[0] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0,        4'b0000, 1'b0, 4'b0000, 12'h000, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 12'h123, 1'b0, 1'b0, 12'h000, 32'h0,        4'b0000, 1'b1, 4'b0000, 12'h123, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h045, 32'hCAFE0001, 4'b1111, 1'b1, 4'b0000, 12'h045, 32'hCAFE0001, 1'b1};
        vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h046, 32'hA1B2C3D4, 4'b1010, 1'b1, 4'b1010, 12'h046, 32'hA1B2C3D4, 1'b1};
        vecs[4] = '{1'b1, 12'h200, 1'b1, 1'b1, 12'h201, 32'h55AA55AA, 4'b1111, 1'b1, 4'b0000, 12'h200, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h050, 32'h0BADF00D, 4'b0000, 1'b1, 4'b0000, 12'h050, 32'h0BADF00D, 1'b1};

        idle();
        arst = 1'b1;
        nxt();
        nxt();
        chk_all_zero("reset");
        arst = 1'b0;
        nxt();

        // ---- table-driven arbitration vectors ----
        for (int i = 0; i < 6; i++) begin
            disp_req_i  = vecs[i].d_req;
            disp_addr_i = vecs[i].d_addr;
            bus_req_i   = vecs[i].b_req;
            bus_we_i    = vecs[i].b_we;
            bus_addr_i  = vecs[i].b_addr;
            bus_wdata_i = vecs[i].b_wdata;
            bus_be_i    = vecs[i].b_be;
            #1;
            chk($sformatf("vec%0d_mem_en", i),    mem_en_o,    vecs[i].e_en);
            chk($sformatf("vec%0d_mem_we", i),    mem_we_o,    vecs[i].e_we);
            chk($sformatf("vec%0d_mem_addr", i),  mem_addr_o,  vecs[i].e_addr);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
            chk($sformatf("vec%0d_bus_gnt", i),   bus_gnt_o,   vecs[i].e_gnt);
            nxt();
            idle();
            nxt();
        end
        nxt();
        nxt();

        // ---- display read only ----
        preload(12'h010, 32'hDEADBEEF);
        disp_req_i  = 1'b1;
        disp_addr_i = 12'h010;
        nxt();
        idle();
        chk("disp_rd_rvalid_t1", disp_rvalid_o, 0);
        nxt();
        chk("disp_rd_rvalid_t2", disp_rvalid_o, 1);
        chk("disp_rd_rdata",     disp_rdata_o,  32'hDEADBEEF);
        chk("disp_rd_bus_rvalid", bus_rvalid_o, 0);
        nxt();
        chk("disp_rd_rvalid_t3", disp_rvalid_o, 0);
        chk("disp_rd_hold",      disp_rdata_o,  32'hDEADBEEF);

        // ---- bus write then read-back ----
        preload(12'h0A5, 32'hFFFFFFFF);
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b1;
        bus_addr_i  = 12'h0A5;
        bus_wdata_i = 32'h12345678;
        bus_be_i    = 4'b0101;
        #1;
        chk("bwr_gnt", bus_gnt_o, 1);
        chk("bwr_mem_we", mem_we_o, 4'b0101);
        nxt();
        bus_we_i = 1'b0;
        bus_be_i = 4'b0000;
        #1;
        chk("brd_gnt", bus_gnt_o, 1);
        nxt();
        idle();
        chk("bwr_no_rvalid", bus_rvalid_o, 0);
        nxt();
        chk("brd_rvalid", bus_rvalid_o, 1);
        chk("brd_rdata",  bus_rdata_o,  32'hFF34FF78);
        chk("brd_disp_rvalid", disp_rvalid_o, 0);
        nxt();
        chk("brd_rvalid_done", bus_rvalid_o, 0);

        // ---- collision: display wins, bus granted a cycle later ----
        pulse_reset();
        preload(12'h300, 32'h30030030);
        preload(12'h033, 32'h03303303);
        disp_req_i  = 1'b1;
        disp_addr_i = 12'h300;
        bus_req_i   = 1'b1;
        bus_addr_i  = 12'h033;
        #1;
        chk("col_gnt_t0", bus_gnt_o, 0);
        chk("col_addr_t0", mem_addr_o, 12'h300);
        nxt();
        disp_req_i = 1'b0;
        #1;
        chk("col_gnt_t1", bus_gnt_o, 1);
        chk("col_cnt", conflict_cnt_o, 1);
        nxt();
        idle();
        chk("col_disp_rvalid", disp_rvalid_o, 1);
        chk("col_disp_rdata",  disp_rdata_o,  32'h30030030);
        chk("col_bus_early",   bus_rvalid_o,  0);
        nxt();
        chk("col_bus_rvalid", bus_rvalid_o, 1);
        chk("col_bus_rdata",  bus_rdata_o,  32'h03303303);

        // ---- same-address write vs display read: display sees old data ----
        preload(12'h077, 32'h11111111);
        disp_req_i  = 1'b1;
        disp_addr_i = 12'h077;
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b1;
        bus_addr_i  = 12'h077;
        bus_wdata_i = 32'h22222222;
        bus_be_i    = 4'b1111;
        nxt();
        disp_req_i = 1'b0;
        #1;
        chk("hz_gnt", bus_gnt_o, 1);
        nxt();
        idle();
        chk("hz_disp_old", disp_rdata_o, 32'h11111111);
        chk("hz_cnt", conflict_cnt_o, 2);
        bus_req_i  = 1'b1;
        bus_addr_i = 12'h077;
        nxt();
        idle();
        nxt();
        chk("hz_bus_new", bus_rdata_o, 32'h22222222);

        // ---- counter saturation ----
        pulse_reset();
        for (int k = 0; k < 20; k++) begin
            disp_req_i = 1'b1;
            bus_req_i  = 1'b1;
            bus_we_i   = 1'b1;
            bus_addr_i = 12'h400;
            nxt();
            disp_req_i = 1'b0;
            nxt();
            if (k == 13) chk("sat_cnt_14", conflict_cnt_o, 4'hE);
        end
        idle();
        chk("sat_cnt_final", conflict_cnt_o, 4'hF);

        // ---- reset in the middle of a bus read ----
        nxt();
        nxt();
        bus_req_i  = 1'b1;
        bus_addr_i = 12'h0A5;
        #1;
        chk("rst_rd_gnt", bus_gnt_o, 1);
        nxt();
        idle();
        arst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        nxt();
        arst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_no_rvalid%0d", k), bus_rvalid_o, 0);
            nxt();
        end
        chk("rst_rdata_clear", bus_rdata_o, 0);

        // ---- random traffic against a shadow memory ----
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            preload(AW'(i), shadow[i]);
        end
        idle();
        b_act  = 1'b0;
        b_wait = 0;
        for (int n = 0; n < 400; n++) begin
            check_rsp();
            disp_req_i  = (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
            disp_addr_i = AW'($urandom_range(0, 15));
            if (!b_act && $urandom_range(0, 2) != 0) begin
                b_act       = 1'b1;
                b_wait      = 0;
                bus_we_i    = 1'($urandom_range(0, 1));
                bus_addr_i  = AW'($urandom_range(0, 15));
                bus_wdata_i = $urandom;
                bus_be_i    = BW'($urandom_range(0, 15));
            end
            bus_req_i = b_act;
            #1;
            if (disp_req_i) begin
                e.due  = cyc + 2;
                e.data = shadow[disp_addr_i[3:0]];
                dq.push_back(e);
            end
            if (b_act) begin
                chk("rnd_gnt", bus_gnt_o, !disp_req_i);
                if (!disp_req_i) begin
                    chk("rnd_wait_le1", (b_wait <= 1), 1);
                    if (bus_we_i) begin
                        m = shadow[bus_addr_i[3:0]];
                        for (int b = 0; b < BW; b++) begin
                            if (bus_be_i[b]) m[8*b +: 8] = bus_wdata_i[8*b +: 8];
                        end
                        shadow[bus_addr_i[3:0]] = m;
                    end else begin
                        e.due  = cyc + 2;
                        e.data = shadow[bus_addr_i[3:0]];
                        bq.push_back(e);
                    end
                    b_act = 1'b0;
                end else begin
                    b_wait++;
                end
            end
            nxt();
        end
        idle();
        for (int n = 0; n < 3; n++) begin
            check_rsp();
            nxt();
        end
        chk("rnd_disp_all_returned", dq.size(), 0);
        chk("rnd_bus_all_returned",  bq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
